online_otf_converter: RTL
=========================

# online_otf_converter

Digit-serial on-the-fly converter (OTFC) that turns a most-significant-digit-first stream of radix-2 signed digits (`signed_digit` from `rbr_pkg`) into a conventional two's-complement integer. The online divider, multiplier and adder chains produce redundant signed-digit results, and this block is their exit point into binary logic. It uses Q/QM register pairs, so it needs no carry-propagate adder. A valid/ready handshake is used on both sides.

## Interface
- `P`, 14: number of signed digits per operand (fraction digits q1..qP).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `clear`  in  1  synchronous abort; discards the partial/held result.
- `in_valid`  in  1  `in_digit` is valid this cycle.
- `in_ready`  out  1  block accepts a digit this cycle.
- `in_digit`  in  `signed_digit`  next digit, MSD first, value in {-1,0,+1} per `rbr_pkg` decode.
- `out_valid`  out  1  `out_data` holds a completed result.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  P+1  two's-complement result = Σ q_j·2^(P−j), j=1..P.
- `out_zero`  out  1  present only with `OTFC_ZERO_FLAG_EN`; see Configuration.

## Operation
- State:
  - Q, QM: P+1-bit signed registers.
  - Digit counter `cnt`: 0..P−1.
  - FSM with states COLLECT and HOLD.
- Reset (async) or `clear` (sync) sets:
  - Q=0, QM=−1 (all ones), cnt=0, state=COLLECT.
  - out_valid=0, out_data=0, out_zero=0.
- COLLECT:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, accept digit q and update:
    - q=+1: Q←2Q+1, QM←2Q.
    - q=0: Q←2Q, QM←2QM+1.
    - q=−1: Q←2QM+1, QM←2QM.
  - After the update, cnt increments.
  - On the P-th accept (cnt==P−1):
    - out_data←new Q.
    - state←HOLD, cnt←0.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_data and out_zero are stable.
  - On out_ready:
    - out_valid←0, Q←0, QM←−1.
    - state←COLLECT.
- Arithmetic:
  - All shifts are within P+1 bits; no overflow is possible.
  - |result| ≤ 2^P−1.
  - Invariant: QM = Q − 1 after every update.
- `in_digit` is ignored when in_valid=0 or in_ready=0.
- `clear` has priority over any simultaneous input or output handshake.
- out_data retains its last value after leaving HOLD until the next completion (reset/clear zero it).

## Timing
- in_ready is a registered function of state only; no combinational path from out_ready.
- One digit is accepted per cycle in COLLECT; gaps in in_valid stall without loss.
- out_valid rises on the clock edge that accepts digit P; latency from the last digit is 1 edge.
- HOLD lasts ≥1 cycle; the first digit of the next operand can be accepted the cycle after the output handshake.
- Peak throughput: one result per P+1 cycles.
- rst_n low mid-operand: all outputs go to reset values immediately (asynchronously); the partial operand is lost.

## Configuration
- `OTFC_ZERO_FLAG_EN` defined:
  - Adds port `out_zero`.
  - Registered alongside out_data at completion: 1 iff the completed Q==0. Resets to 0.
  - Cost: one P+1-input NOR plus a flop.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- P=4, digits +1,0,−1,+1 back-to-back, out_ready=1 → out_valid one edge after the 4th accept, out_data=5'b00111 (7).
- P=4, digits −1,−1,−1,−1 → out_data=5'b10001 (−15).
- P=4, digits +1,−1,+1,−1 with in_valid low for 2 cycles between digits 2 and 3 → out_data=5'b00101 (5).
- P=4, digits 0,0,0,0 → out_data=0; out_zero=1 with the macro defined.
- Backpressure: completion with out_ready=0 for 3 cycles → out_valid=1, in_ready=0, out_data stable; out_ready=1 → next edge out_valid=0, in_ready=1.
- Abort cases:
  - rst_n pulsed low after 2 digits → outputs zero immediately; next 4 digits +1,0,0,0 → out_data=8.
  - `clear` asserted with out_ready in HOLD → identical reset state; `clear` wins.

Source files
------------

// File: rtl/online_otf_converter.sv
// Digit-serial on-the-fly converter: MSD-first radix-2 signed digits to two's complement via Q/QM.
// Optional zero flag output enabled by defining OTFC_ZERO_FLAG_EN.

package rbr_pkg;
   // Borrow-save digit: value = pos - neg; {0,0} and {1,1} both encode zero.
   typedef struct packed {
      logic pos;
      logic neg;
   } signed_digit;
endpackage

module online_otf_converter #(
   parameter int unsigned P = 14
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  rbr_pkg::signed_digit in_digit_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [P:0]          out_data_o
`ifdef OTFC_ZERO_FLAG_EN
   ,
   output logic                out_zero_o
`endif
);

   localparam int unsigned    CntW    = (P > 1) ? $clog2(P) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(P - 1);
   localparam logic [P:0]     One     = {{P{1'b0}}, 1'b1};

   typedef enum logic [0:0] {StCollect, StHold} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [P:0]      q_q, qm_q;
   logic [P:0]      q_d, qm_d;
   logic [P:0]      out_data_q;
   logic            out_valid_q;
   logic            in_ready_q;
   logic            digit_plus, digit_minus;
   logic            accept;
`ifdef OTFC_ZERO_FLAG_EN
   logic            out_zero_q;
`endif

   assign digit_plus  = in_digit_i.pos & ~in_digit_i.neg;
   assign digit_minus = in_digit_i.neg & ~in_digit_i.pos;
   assign accept      = in_valid_i & in_ready_q;

   // Appending a digit never needs a carry: pick the shifted Q or QM and set the new LSB.
   always_comb begin
      q_d  = q_q << 1;
      qm_d = qm_q << 1;
      if (digit_plus) begin
         q_d  = (q_q << 1) | One;
         qm_d = q_q << 1;
      end else if (digit_minus) begin
         q_d  = (qm_q << 1) | One;
         qm_d = qm_q << 1;
      end else begin
         q_d  = q_q << 1;
         qm_d = (qm_q << 1) | One;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StCollect;
         cnt_q       <= '0;
         q_q         <= '0;
         qm_q        <= '1;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef OTFC_ZERO_FLAG_EN
         out_zero_q  <= 1'b0;
`endif
      end else if (clear_i) begin
         state_q     <= StCollect;
         cnt_q       <= '0;
         q_q         <= '0;
         qm_q        <= '1;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef OTFC_ZERO_FLAG_EN
         out_zero_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StCollect: begin
               if (accept) begin
                  q_q  <= q_d;
                  qm_q <= qm_d;
                  if (cnt_q == LastCnt) begin
                     cnt_q       <= '0;
                     out_data_q  <= q_d;
                     out_valid_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                     state_q     <= StHold;
`ifdef OTFC_ZERO_FLAG_EN
                     out_zero_q  <= ~|q_d;
`endif
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            StHold: begin
               if (out_ready_i) begin
                  q_q         <= '0;
                  qm_q        <= '1;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StCollect;
               end
            end
            default: state_q <= StCollect;
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
`ifdef OTFC_ZERO_FLAG_EN
   assign out_zero_o  = out_zero_q;
`endif

endmodule
